s_axi_stream_buffer: RTL
========================

Name: s_axi_stream_buffer

Overview:
AXI4-Stream slave that sits directly downstream of the counter-pattern stream master. It accepts one frame of up to 2**BUFSIZE words into an internal buffer and reports the frame length, a running word sum and error flags. The core reads the buffer through a random-access port and then releases it for the next frame. It is the receive-side counterpart used to close the loopback path and check the master's output.

Parameters:
DWIDTH, 32, stream and buffer word width in bits (multiple of 8)
BUFSIZE, 4, log2 of buffer depth; WORDS = 2**BUFSIZE

Ports:
clk  input  1  single clock; all logic on rising edge
xrst  input  1  reset, synchronous, active-high; when high at a rising edge, all state returns to reset values
tvalid  input  1  stream data valid
tdata  input  DWIDTH  stream data
tstrb  input  DWIDTH/8  byte strobes; all ones expected
tlast  input  1  last beat of frame
tready  output  1  stream ready
frame_valid  output  1  a complete frame is held in the buffer
frame_len  output  BUFSIZE+1  number of words stored (1..WORDS)
frame_sum  output  DWIDTH  sum of stored words, modulo 2**DWIDTH
ovf_err  output  1  frame exceeded WORDS beats; excess beats discarded
strb_err  output  1  at least one accepted beat had tstrb not all ones
rd_addr  input  BUFSIZE  core read address
rd_data  output  DWIDTH  buffer word at rd_addr, registered
frame_ack  input  1  core releases the buffer (single-cycle pulse)

Behaviour:
- Beat accepted when tvalid && tready at a rising edge.
- tready is combinational from state only: 1 in S_RECV and S_FLUSH, 0 in S_HOLD. It never depends on tvalid.
- State encoding: S_RECV=0, S_FLUSH=1, S_HOLD=2. Reset state is S_RECV.
- Reset values: wr_ptr=0, frame_valid=0, frame_len=0, frame_sum=0, ovf_err=0, strb_err=0, rd_data=0. Buffer RAM contents are not reset.
- S_RECV, on each accepted beat:
  - mem[wr_ptr] <= tdata; sum += tdata; wr_ptr++.
  - If tstrb != all ones, set strb_err (sticky). Data is stored unmodified.
- S_RECV transitions:
  - Beat with tlast: frame_len <= wr_ptr+1; go to S_HOLD.
  - Beat at wr_ptr==WORDS-1 without tlast: store it, frame_len <= WORDS, ovf_err <= 1; go to S_FLUSH.
  - Both conditions on the same beat (tlast at the WORDS-th beat): normal completion, ovf_err stays 0.
- S_FLUSH: accept beats and discard them (no write, no sum update, strb not checked). The beat with tlast moves the block to S_HOLD.
- S_HOLD:
  - frame_valid=1. It rises on the cycle after the accepting edge of the tlast beat.
  - frame_len, frame_sum and the error flags are stable.
- Read port: rd_data <= mem[rd_addr] every cycle, in any state, with one-cycle latency. Addresses >= frame_len return stale contents; the core must not rely on them.
- frame_ack:
  - In S_HOLD: next state is S_RECV; wr_ptr, sum, frame_len, ovf_err and strb_err clear; frame_valid drops at the same edge. tready is high in the following cycle.
  - In S_RECV or S_FLUSH: ignored.
- Sum arithmetic: DWIDTH-bit wraparound add, no carry out.
- Reset mid-frame: partial frame abandoned, return to S_RECV with reset values. The upstream is not notified.
- No simultaneous write/read hazard handling is needed: writes only occur outside S_HOLD, and reads are only meaningful in S_HOLD.

Test Plan:
- Nominal frame: DWIDTH=32, BUFSIZE=4; 16 beats of data 1..16, tstrb=4'hF, tlast on beat 16 -> frame_valid=1 one cycle after beat 16, frame_len=16, frame_sum=136, ovf_err=0, strb_err=0, tready=0; rd_addr=5 -> rd_data=6 on the next cycle.
- Short frame: beats 7,8,9 with tlast on 9 -> frame_len=3, frame_sum=24. Pulse frame_ack -> frame_valid=0 and tready=1 the next cycle; a second 2-beat frame 1,2 -> frame_len=2, frame_sum=3.
- Overflow: 20 beats 1..20, tlast on 20 -> tready stays high through beat 20, frame_len=16, frame_sum=136, ovf_err=1; rd_addr=15 -> rd_data=16.
- Backpressure and gaps: tvalid toggled randomly for a 16-beat frame, then a second frame held valid during S_HOLD -> no beat accepted while tready=0. After frame_ack, the second frame is accepted intact with the correct sum.
- Strobe error: beat 4 of an 8-beat frame with tstrb=4'h3 -> strb_err=1, data stored unmodified, frame_len=8.
- Reset mid-frame: xrst high for 1 cycle after 5 beats -> all outputs 0, tready=1. A following 4-beat frame 1..4 -> frame_len=4, frame_sum=10.

Source files
------------

// File: rtl/s_axi_stream_buffer_if.sv
// AXI4-Stream bundle between a stream master and s_axi_stream_buffer.
//   tvalid/tdata/tstrb/tlast : master -> slave
//   tready                   : slave  -> master
interface s_axi_stream_buffer_if #(
  parameter int DWIDTH = 32
);
  logic              tvalid;
  logic [DWIDTH-1:0] tdata;
  logic [DWIDTH/8-1:0] tstrb;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/s_axi_stream_buffer.sv
// Receive-side frame buffer for an AXI4-Stream source. Captures one frame of
// up to 2**BUFSIZE words, reports length / running sum / error flags, and
// holds the frame for random-access reads until the core acks it.
//   clk, xrst    : clock, synchronous active-high reset
//   s            : stream slave port (tvalid/tdata/tstrb/tlast in, tready out)
//   frame_valid  : complete frame held in buffer
//   frame_len    : stored word count (1..WORDS)
//   frame_sum    : sum of stored words mod 2**DWIDTH
//   ovf_err      : frame longer than WORDS, excess beats dropped
//   strb_err     : an accepted, stored beat had a partial strobe
//   rd_addr/data : registered read port, one-cycle latency
//   frame_ack    : release buffer (honoured only while holding)
module s_axi_stream_buffer #(
  parameter int DWIDTH  = 32,
  parameter int BUFSIZE = 4
) (
  input  logic               clk,
  input  logic               xrst,
  s_axi_stream_buffer_if.slave s,
  output logic               frame_valid,
  output logic [BUFSIZE:0]   frame_len,
  output logic [DWIDTH-1:0]  frame_sum,
  output logic               ovf_err,
  output logic               strb_err,
  input  logic [BUFSIZE-1:0] rd_addr,
  output logic [DWIDTH-1:0]  rd_data,
  input  logic               frame_ack
);
  localparam int WORDS = 2**BUFSIZE;

  typedef enum logic [1:0] {S_RECV = 2'd0, S_FLUSH = 2'd1, S_HOLD = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [BUFSIZE-1:0] wr_ptr;
  logic [DWIDTH-1:0]  mem [WORDS];
  logic               accept;
  logic               last_slot;

  assign accept    = s.tvalid && s.tready;
  assign last_slot = (wr_ptr == BUFSIZE'(WORDS-1));

  always_comb begin
    state_nxt   = state;
    s.tready    = 1'b1;
    frame_valid = 1'b0;
    case (state)
      S_RECV: begin
        // tlast wins when it lands on the final slot: clean completion
        if (accept && s.tlast)     state_nxt = S_HOLD;
        else if (accept && last_slot) state_nxt = S_FLUSH;
      end
      S_FLUSH: if (accept && s.tlast) state_nxt = S_HOLD;
      S_HOLD: begin
        s.tready    = 1'b0;
        frame_valid = 1'b1;
        if (frame_ack) state_nxt = S_RECV;
      end
      default: state_nxt = S_RECV;
    endcase
  end

  // Buffer RAM: no reset, written only while receiving
  always_ff @(posedge clk) begin
    if (state == S_RECV && accept) mem[wr_ptr] <= s.tdata;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state     <= S_RECV;
      wr_ptr    <= '0;
      frame_len <= '0;
      frame_sum <= '0;
      ovf_err   <= 1'b0;
      strb_err  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state   <= state_nxt;
      rd_data <= mem[rd_addr];
      case (state)
        S_RECV: if (accept) begin
          frame_sum <= frame_sum + s.tdata;
          wr_ptr    <= wr_ptr + BUFSIZE'(1);
          if (!(&s.tstrb)) strb_err <= 1'b1;
          if (s.tlast) begin
            frame_len <= (BUFSIZE+1)'(wr_ptr) + (BUFSIZE+1)'(1);
          end else if (last_slot) begin
            frame_len <= (BUFSIZE+1)'(WORDS);
            ovf_err   <= 1'b1;
          end
        end
        S_HOLD: if (frame_ack) begin
          wr_ptr    <= '0;
          frame_len <= '0;
          frame_sum <= '0;
          ovf_err   <= 1'b0;
          strb_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
